// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//   Two-requester arbiter in front of a single-port, synchronous-read
//   instruction memory. One read is issued per cycle. Read data comes back
//   one cycle later on the port that issued it.
//
//   Configuration macro: IMEM_ARB_RR_EN
//     defined   -> round-robin on contention (the port not granted most
//                  recently wins)
//     undefined -> fixed priority, port 0 always wins contention
//
// Parameters
//   DATA_WIDTH  instruction word width
//   ADDR_WIDTH  word address width of the shared memory
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   req_valid_0/1       read request from requester 0/1
//   req_addr_0/1        word address, valid with req_valid_x
//   req_ready_0/1       request accepted this cycle (combinational grant)
//   rsp_valid_0/1       one-cycle pulse: read data returned to requester
//   rsp_data_0/1        read data; zero when the port is not responding
//   mem_addr            address to the memory (granted address, else held)
//   mem_data            memory read data, valid one cycle after mem_addr
//   busy                a response is in flight (read issued last cycle)
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    output logic                  req_ready_0,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_data_0,
    input  logic                  req_valid_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    output logic                  req_ready_1,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_data_1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy
);

    logic [1:0]            req_valid;
    logic [1:0]            grant;
    logic                  transfer;
    logic                  grant_id;

    // Issue-stage pipeline register: which port's read is in flight.
    logic                  issued_valid_reg;
    logic                  issued_id_reg;
    logic [ADDR_WIDTH-1:0] held_addr_reg;

    logic [1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data [2];

    assign req_valid = {req_valid_1, req_valid_0};

`ifdef IMEM_ARB_RR_EN
    // Id of the port that won the most recent transfer. Reset value 1 makes
    // port 0 the winner of the first contention after reset.
    logic last_id_reg;

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_id_reg ? 2'b01 : 2'b10;
        end
        // No grant can be issued while reset is held.
        if (!rst) begin
            grant = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_id_reg <= 1'b1;
        end else if (transfer) begin
            last_id_reg <= grant_id;
        end
    end
`else
    always_comb begin
        grant    = 2'b00;
        grant[0] = req_valid[0];
        grant[1] = req_valid[1] & ~req_valid[0];
        if (!rst) begin
            grant = 2'b00;
        end
    end
`endif

    assign transfer = |grant;
    assign grant_id = grant[1];

    assign req_ready_0 = grant[0];
    assign req_ready_1 = grant[1];

    // The memory sees the granted address directly so data is ready next
    // cycle; between grants the last address is held to keep the bus stable.
    always_comb begin
        mem_addr = held_addr_reg;
        if (grant[0]) begin
            mem_addr = req_addr_0;
        end else if (grant[1]) begin
            mem_addr = req_addr_1;
        end
    end

    // Asynchronous clear drops any in-flight response so it is never
    // delivered after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_valid_reg <= 1'b0;
            issued_id_reg    <= 1'b0;
            held_addr_reg    <= '0;
        end else begin
            issued_valid_reg <= transfer;
            if (transfer) begin
                issued_id_reg <= grant_id;
                held_addr_reg <= mem_addr;
            end
        end
    end

    // Response routing depends only on the recorded issuer, never on the
    // current cycle's grant, so back-to-back issues stay correctly ordered.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid[gi] = issued_valid_reg && (issued_id_reg == 1'(gi));
        assign rsp_data[gi]  = rsp_valid[gi] ? mem_data : '0;
    end

    assign rsp_valid_0 = rsp_valid[0];
    assign rsp_valid_1 = rsp_valid[1];
    assign rsp_data_0  = rsp_data[0];
    assign rsp_data_1  = rsp_data[1];
    assign busy        = issued_valid_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//   Directed stimulus for imem_arbiter with a synchronous-read memory model
//   (word at address a is a, except word 5 = 0xDEADBEEF). A cycle-level
//   behavioural model checks every output on every falling edge; directed
//   literal checks pin the key scenarios. Honours IMEM_ARB_RR_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

`ifdef IMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_0 = 1'b0;
    logic [AW-1:0] req_addr_0 = '0;
    logic          req_ready_0;
    logic          rsp_valid_0;
    logic [DW-1:0] rsp_data_0;
    logic          req_valid_1 = 1'b0;
    logic [AW-1:0] req_addr_1 = '0;
    logic          req_ready_1;
    logic          rsp_valid_1;
    logic [DW-1:0] rsp_data_1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic          busy;

    int total = 0;
    int bad   = 0;

    imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_addr_0(req_addr_0), .req_ready_0(req_ready_0),
        .rsp_valid_0(rsp_valid_0), .rsp_data_0(rsp_data_0),
        .req_valid_1(req_valid_1), .req_addr_1(req_addr_1), .req_ready_1(req_ready_1),
        .rsp_valid_1(rsp_valid_1), .rsp_data_1(rsp_data_1),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return (a == 10'd5) ? 32'hDEADBEEF : 32'(a);
    endfunction

    // Synchronous-read memory.
    always @(posedge clk) mem_data <= word(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model + compare process -----------------
    int            last_port = 1;  // port granted most recently
    bit            pend_v = 0;     // a read issued last cycle
    int            pend_p = 0;
    logic [DW-1:0] pend_d = '0;
    logic [AW-1:0] held = '0;

    always @(negedge clk) begin
        int g;
        logic [AW-1:0] ea;
        if (!rst) begin
            pend_v = 0; last_port = 1; held = '0;
            chk("m_rst_ready0", 32'(req_ready_0), 0);
            chk("m_rst_ready1", 32'(req_ready_1), 0);
            chk("m_rst_rspv", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
            chk("m_rst_data0", rsp_data_0, 0);
            chk("m_rst_data1", rsp_data_1, 0);
            chk("m_rst_busy", 32'(busy), 0);
            chk("m_rst_addr", 32'(mem_addr), 0);
        end else begin
            g = -1;
            if (req_valid_0 && req_valid_1) g = RR ? 1 - last_port : 0;
            else if (req_valid_0)           g = 0;
            else if (req_valid_1)           g = 1;
            ea = (g == 0) ? req_addr_0 : (g == 1) ? req_addr_1 : held;
            chk("m_ready0", 32'(req_ready_0), 32'(g == 0));
            chk("m_ready1", 32'(req_ready_1), 32'(g == 1));
            chk("m_addr", 32'(mem_addr), 32'(ea));
            chk("m_rspv0", 32'(rsp_valid_0), 32'(pend_v && pend_p == 0));
            chk("m_rspv1", 32'(rsp_valid_1), 32'(pend_v && pend_p == 1));
            chk("m_data0", rsp_data_0, (pend_v && pend_p == 0) ? pend_d : 0);
            chk("m_data1", rsp_data_1, (pend_v && pend_p == 1) ? pend_d : 0);
            chk("m_busy", 32'(busy), 32'(pend_v));
            // advance to the upcoming rising edge
            pend_v = (g >= 0);
            pend_p = (g >= 0) ? g : 0;
            pend_d = word(ea);
            if (g >= 0) begin
                held = ea;
                last_port = g;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input bit v0, input logic [AW-1:0] a0, input bit v1, input logic [AW-1:0] a1);
        @(posedge clk); #1;
        req_valid_0 = v0; req_addr_0 = a0;
        req_valid_1 = v1; req_addr_1 = a1;
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid_0 = 0; req_valid_1 = 0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int expg;
        int prevg;
        // Reset held with port 0 requesting: no grant may appear.
        req_valid_0 = 1; req_addr_0 = 10'h005;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready0", 32'(req_ready_0), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_addr", 32'(mem_addr), 0);
        end

        // First read after release: addr 5 -> 0xDEADBEEF one cycle later.
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("first_ready0", 32'(req_ready_0), 1);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("first_rspv0", 32'(rsp_valid_0), 1);
        chk("first_data0", rsp_data_0, 32'hDEADBEEF);
        chk("first_rspv1", 32'(rsp_valid_1), 0);

        // Continuous contention, addrs 0x010 / 0x020.
        pulse_reset(2);
        prevg = -1;
        for (int k = 0; k < 6; k++) begin
            step(1, 10'h010, 1, 10'h020);
            @(negedge clk);
            expg = RR ? (k % 2) : 0;
            chk("cont_ready0", 32'(req_ready_0), 32'(expg == 0));
            chk("cont_ready1", 32'(req_ready_1), 32'(expg == 1));
            if (prevg == 0) chk("cont_rsp0", rsp_data_0, 32'h10);
            if (prevg == 1) chk("cont_rsp1", rsp_data_1, 32'h20);
            prevg = expg;
        end
        // Port 0 drops: port 1 granted at once.
        step(0, 0, 1, 10'h020);
        @(negedge clk);
        chk("drop_ready1", 32'(req_ready_1), 1);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("drop_rsp1", rsp_data_1, 32'h20);

        // Port 1 back-to-back 1,2,3.
        step(0, 0, 1, 10'h001);
        @(negedge clk);
        chk("b2b_ready1", 32'(req_ready_1), 1);
        for (int k = 2; k <= 4; k++) begin
            step(0, 0, (k <= 3), 10'(k));
            @(negedge clk);
            chk("b2b_rspv1", 32'(rsp_valid_1), 1);
            chk("b2b_data1", rsp_data_1, 32'(k - 1));
            chk("b2b_busy", 32'(busy), 1);
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 0);

        // Losing requester withdraws: no response for it.
        step(1, 10'h040, 1, 10'h041);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Reset in the cycle after a transfer discards the response.
        step(1, 10'h033, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid_0 = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rspv0", 32'(rsp_valid_0), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        req_valid_0 = 1; req_addr_0 = 10'h010;
        req_valid_1 = 1; req_addr_1 = 10'h020;
        @(negedge clk);
        chk("arst_win0", 32'(req_ready_0), 1);
        chk("arst_lose1", 32'(req_ready_1), 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("arst_rsp0", rsp_data_0, 32'h10);

        // Read of 0x07F then 5 idle cycles: address held, nothing returned.
        step(1, 10'h07F, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("hold_rsp0", rsp_data_0, 32'h7F);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step(0, 0, 0, 0);
            if (k > 0) @(negedge clk);
            chk("hold_addr", 32'(mem_addr), 32'h7F);
            if (k > 0) chk("hold_busy", 32'(busy), 0);
            if (k > 0) chk("hold_rspv0", 32'(rsp_valid_0), 0);
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter: ADDR_WIDTH, default 10, word address width of the shared instruction memory.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Ports, requester r in {0,1}: req_valid_r  input  1  read request.
REQ-006 Ports, requester r: req_addr_r  input  ADDR_WIDTH  word address, valid with req_valid_r.
REQ-007 Ports, requester r: req_ready_r  output  1  request accepted this cycle (combinational grant).
REQ-008 Ports, requester r: rsp_valid_r  output  1  read data returned, one-cycle pulse.
REQ-009 Ports, requester r: rsp_data_r  output  DATA_WIDTH  read data, valid with rsp_valid_r.
REQ-010 Port: mem_addr  output  ADDR_WIDTH  address to the synchronous-read instruction memory.
REQ-011 Port: mem_data  input  DATA_WIDTH  memory read data, registered inside memory, valid one cycle after mem_addr.
REQ-012 Port: busy  output  1  a response is in flight (issued last cycle).

Function
REQ-013 Transfer on requester r occurs in cycle N when req_valid_r and req_ready_r are both high at the rising edge.
REQ-014 At most one transfer per cycle; sustained throughput one read per cycle, no bubble between back-to-back transfers.
REQ-015 At most one req_ready_r high per cycle; req_ready_r never high while req_valid_r low.
REQ-016 Grant in a cycle with a single requesting port: that port, unconditionally.
REQ-017 Grant when both request: per arbitration policy (REQ-029/REQ-030).
REQ-018 mem_addr = req_addr of granted port in a granting cycle; otherwise holds last granted address (registered copy), never X.
REQ-019 Latency: transfer in cycle N -> rsp_valid_r high in cycle N+1 only, rsp_data_r = mem_data in cycle N+1.
REQ-020 Pipeline register {issued_valid, issued_id} records the cycle-N transfer; rsp routing uses only issued_id, never current grant.
REQ-021 rsp_data_r of the non-responding port driven to zero; rsp_valid of both ports never high together.
REQ-022 No response backpressure: requesters must consume rsp in the cycle it is valid.
REQ-023 Requester dropping req_valid without transfer: legal, no state change, no response.
REQ-024 Same requester granted in consecutive cycles: responses return in issue order, one per cycle.
REQ-025 busy = issued_valid.

Reset
REQ-026 rst low: immediately clear issued_valid, issued_id=0, last-granted pointer=1 (port 0 wins first contention), held mem_addr=0.
REQ-027 During reset: req_ready_r=0, rsp_valid_r=0, rsp_data_r=0, busy=0, mem_addr=0.
REQ-028 Reset asserted with a response in flight: response discarded, never delivered after reset release; first grant possible in first cycle with rst high.

Configuration
REQ-029 Macro IMEM_ARB_RR_EN defined: round-robin; on contention grant the port not granted most recently; pointer updates only on a transfer.
REQ-030 Macro IMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins contention; no last-granted pointer state, all other requirements unchanged.

Verification
REQ-031 Reset release, port 0 req addr 0x005, mem word 5 = 0xDEADBEEF -> req_ready_0 high cycle N, rsp_valid_0 cycle N+1 with rsp_data_0=0xDEADBEEF, rsp_valid_1 low.
REQ-032 Both ports request continuously, addrs 0x010/0x020, RR_EN defined -> grants alternate 0,1,0,1; responses alternate, one per cycle, correct data per port.
REQ-033 Same stimulus, RR_EN undefined -> port 0 granted every cycle, req_ready_1 never high, port 1 granted first cycle after port 0 drops req_valid.
REQ-034 Port 1 back-to-back addrs 0x001,0x002,0x003 -> rsp_valid_1 three consecutive cycles, data words 1,2,3 in order, busy high for those three cycles.
REQ-035 rst asserted in the cycle after a transfer -> rsp_valid_0/1 stay 0, busy 0, mem_addr 0 asynchronously; after release first contention won by port 0.
REQ-036 No requests for 5 cycles after a read of 0x07F -> mem_addr holds 0x07F, no rsp_valid, busy low.
